// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer for the MIPS datapath.
// Issues sequential fetch addresses, applies JR/J/branch redirects and flushes IF/ID after each redirect.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] imm_ext,
    input  logic [31:0] id_pc_plus4,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target,
    output logic        fetch_valid,
    output logic        flush,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        misaligned_q, misaligned_d;

    logic [31:0] jump_target;
    logic [31:0] jr_target_aligned;
    logic [31:0] redirect_target;
    logic        redirect;

    // The top two immediate bits fall off the end of the word shift.
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm_ext[31:30];

    assign pc_plus4          = pc_q + 32'd4;
    assign branch_target     = id_pc_plus4 + {imm_ext[29:0], 2'b00};
    assign jump_target       = {id_pc_plus4[31:28], jump_index, 2'b00};
    assign jr_target_aligned = {jr_target[31:2], 2'b00};
    assign redirect          = jr | jump | branch_taken;

    always_comb begin
        redirect_target = branch_target;
        if (jr) begin
            redirect_target = jr_target_aligned;
        end else if (jump) begin
            redirect_target = jump_target;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        misaligned_d = misaligned_q;
        fetch_valid  = 1'b0;
        flush        = 1'b0;
        case (state_q)
            ST_INIT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                fetch_valid = imem_ready & ~stall;
                if (!stall) begin
                    if (redirect) begin
                        pc_d    = redirect_target;
                        state_d = ST_REDIRECT;
                        if (jr && (jr_target[1:0] != 2'b00)) begin
                            misaligned_d = 1'b1;
                        end
                    end else if (imem_ready) begin
                        pc_d = pc_plus4;
                    end
                end
            end
            ST_REDIRECT: begin
                // Redirect inputs here belong to the instruction being squashed.
                flush   = 1'b1;
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, whatever the block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            pc_q         <= RESET_PC;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign pc         = pc_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: the driver queues hand-computed expectations,
// a monitor pops and compares them mid-cycle (or on demand for async events).
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ready;
    logic        stall;
    logic        branch_taken;
    logic [31:0] imm_ext;
    logic [31:0] id_pc_plus4;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic        fetch_valid;
    logic        flush;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        fv;
        logic        fl;
        logic        mis;
        logic        chk_bt;
        logic [31:0] bt;
    } exp_t;

    exp_t sb[$];
    event sample_ev;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_ready   (imem_ready),
        .stall        (stall),
        .branch_taken (branch_taken),
        .imm_ext      (imm_ext),
        .id_pc_plus4  (id_pc_plus4),
        .jump         (jump),
        .jump_index   (jump_index),
        .jr           (jr),
        .jr_target    (jr_target),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .branch_target(branch_target),
        .fetch_valid  (fetch_valid),
        .flush        (flush),
        .misaligned   (misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, actual, required, $time);
        end
    endtask

    task automatic push_exp(input string name, input logic [31:0] exp_pc, input logic fv,
                            input logic fl, input logic mis,
                            input logic chk_bt = 1'b0, input logic [31:0] bt = 32'h0);
        exp_t e;
        e.name = name; e.pc = exp_pc; e.fv = fv; e.fl = fl; e.mis = mis;
        e.chk_bt = chk_bt; e.bt = bt;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        branch_taken = 1'b0;
        jump         = 1'b0;
        jr           = 1'b0;
    endtask

    // Monitor: compares queued expectations against the live outputs.
    initial begin
        forever begin
            @(negedge clk or sample_ev);
            while (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, ".pc"}, pc, e.pc);
                check({e.name, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
                check({e.name, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e.fv});
                check({e.name, ".flush"}, {31'd0, flush}, {31'd0, e.fl});
                check({e.name, ".misaligned"}, {31'd0, misaligned}, {31'd0, e.mis});
                if (e.chk_bt) check({e.name, ".branch_target"}, branch_target, e.bt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        imem_ready   = 1'b1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        imm_ext      = 32'h0;
        id_pc_plus4  = 32'h0;
        jump         = 1'b0;
        jump_index   = 26'h0;
        jr           = 1'b0;
        jr_target    = 32'h0;

        #3;
        push_exp("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        step();
        step();
        reset = 1'b0;

        // Reset then run: INIT cycle, then one word per cycle.
        push_exp("init", 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 8; i++) begin
            push_exp($sformatf("run%0d", i), 32'(i * 4), 1'b1, 1'b0, 1'b0);
            step();
        end

        // Memory wait at 0x20.
        imem_ready = 1'b0;
        push_exp("wait0", 32'h20, 1'b0, 1'b0, 1'b0);
        step();
        push_exp("wait1", 32'h20, 1'b0, 1'b0, 1'b0);
        step();
        imem_ready = 1'b1;
        push_exp("wait_go", 32'h20, 1'b1, 1'b0, 1'b0);
        step();

        // Backward branch: 0x104 + (-2 << 2) = 0xFC.
        id_pc_plus4  = 32'h0000_0104;
        imm_ext      = 32'hFFFF_FFFE;
        branch_taken = 1'b1;
        push_exp("bbr_issue", 32'h24, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_00FC);
        step();
        push_exp("bbr_flush", 32'hFC, 1'b0, 1'b1, 1'b0);
        step();
        clear_redirects();
        push_exp("bbr_fetch", 32'hFC, 1'b1, 1'b0, 1'b0);
        step();
        push_exp("bbr_next", 32'h100, 1'b1, 1'b0, 1'b0);
        step();

        // Stall beats a pending branch: target 0x200 + 0x40 = 0x240.
        stall        = 1'b1;
        branch_taken = 1'b1;
        id_pc_plus4  = 32'h0000_0200;
        imm_ext      = 32'h0000_0010;
        for (int i = 0; i < 3; i++) begin
            push_exp($sformatf("stall%0d", i), 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0240);
            step();
        end
        stall = 1'b0;
        push_exp("stall_rel", 32'h104, 1'b1, 1'b0, 1'b0);
        step();
        clear_redirects();
        push_exp("stall_flush", 32'h240, 1'b0, 1'b1, 1'b0);
        step();
        push_exp("stall_fetch", 32'h240, 1'b1, 1'b0, 1'b0);
        step();

        // Redirect to the current pc still flushes: 0x248 + (-1 << 2) = 0x244.
        id_pc_plus4  = 32'h0000_0248;
        imm_ext      = 32'hFFFF_FFFF;
        branch_taken = 1'b1;
        push_exp("self_issue", 32'h244, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0244);
        step();
        clear_redirects();
        push_exp("self_flush", 32'h244, 1'b0, 1'b1, 1'b0);
        step();
        push_exp("self_fetch", 32'h244, 1'b1, 1'b0, 1'b0);
        step();

        // jr beats jump and branch; misaligned target is word-aligned and sticky.
        id_pc_plus4  = 32'h0000_1000;
        imm_ext      = 32'h0;
        jr           = 1'b1;
        jr_target    = 32'h0040_0002;
        jump         = 1'b1;
        jump_index   = 26'h000_0010;
        branch_taken = 1'b1;
        push_exp("jr_issue", 32'h248, 1'b1, 1'b0, 1'b0);
        step();
        clear_redirects();
        push_exp("jr_flush", 32'h0040_0000, 1'b0, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 10; i++) begin
            push_exp($sformatf("jr_run%0d", i), 32'h0040_0000 + 32'(i * 4), 1'b1, 1'b0, 1'b1);
            step();
        end

        // jump beats branch: {0x1, 0x40, 00} = 0x1000_0100.
        id_pc_plus4  = 32'h1000_0000;
        imm_ext      = 32'h0000_0008;
        jump         = 1'b1;
        jump_index   = 26'h000_0040;
        branch_taken = 1'b1;
        push_exp("j_issue", 32'h0040_0028, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1000_0020);
        step();
        clear_redirects();
        push_exp("j_flush", 32'h1000_0100, 1'b0, 1'b1, 1'b1);
        step();

        // PC wrap at the top of the address space.
        jr        = 1'b1;
        jr_target = 32'hFFFF_FFFC;
        push_exp("wrap_issue", 32'h1000_0100, 1'b1, 1'b0, 1'b1);
        step();
        clear_redirects();
        push_exp("wrap_flush", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1);
        step();
        push_exp("wrap_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1);
        step();
        push_exp("wrap_zero", 32'h0, 1'b1, 1'b0, 1'b1);
        step();

        // Async reset while in REDIRECT, away from any clock edge.
        id_pc_plus4  = 32'h0000_0100;
        imm_ext      = 32'h0;
        branch_taken = 1'b1;
        push_exp("ar_issue", 32'h4, 1'b1, 1'b0, 1'b1);
        step();
        clear_redirects();
        push_exp("ar_pre", 32'h100, 1'b0, 1'b1, 1'b1);
        -> sample_ev;
        #1;
        reset = 1'b1;
        #1;
        push_exp("ar_async", 32'h0, 1'b0, 1'b0, 1'b0);
        -> sample_ev;
        #1;
        step();
        reset = 1'b0;
        push_exp("ar_init", 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        push_exp("ar_fetch", 32'h0, 1'b1, 1'b0, 1'b0);
        step();

        @(negedge clk);
        #1;
        check("drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
